// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared state encoding, register-zero constant and opcodes for the hazard controller.
package pipe_ctrl_pkg;
    typedef enum logic [1:0] {RUN, LU_STALL, MEM_WAIT, ERR} state_t;
    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam logic [5:0] Rformat = 6'b000000;
    localparam logic [5:0] LW      = 6'b100011;
    localparam logic [5:0] SW      = 6'b101011;
    localparam logic [5:0] BEQ     = 6'b000100;
endpackage

// File: rtl/pipe_sat_counter.sv
// pipe_sat_counter: event counter that sticks at all-ones instead of wrapping.
module pipe_sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] cnt
);
    logic [WIDTH-1:0] r_cnt;
    always_ff @(posedge clk)
        if (rst) r_cnt <= '0;
        else if (inc && !(&r_cnt)) r_cnt <= r_cnt + 1'b1;
    assign cnt = r_cnt;
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: load-use / branch-flush / memory-wait stall controller with timeout trap.
// Define HAZARD_PERF_CNT_EN to add saturating performance counters.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       idex_memread,
    input  logic [4:0] idex_rt,
    input  logic [4:0] ifid_rs,
    input  logic [4:0] ifid_rt,
    input  logic       exmem_branch_taken,
    input  logic       mem_req,
    input  logic       mem_ack,
    output logic       pc_write,
    output logic       ifid_write,
    output logic       ifid_flush,
    output logic       idex_bubble,
    output logic       exmem_bubble,
    output logic       pipe_hold,
    output logic       mem_err
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] lu_stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] mem_wait_cnt
`endif
);
    state_t     r_state, w_state_nx;
    logic [7:0] r_tmo, w_tmo_nx;
    logic       w_active, w_mem_wait, w_flush, w_lu;

    always_ff @(posedge clk)
        if (rst) begin
            r_state <= RUN;
            r_tmo   <= '0;
        end else begin
            r_state <= w_state_nx;
            r_tmo   <= w_tmo_nx;
        end

    // LU_STALL behaves like RUN except that load-use detection is masked
    always_comb begin
        w_active   = r_state == RUN || r_state == LU_STALL;
        w_mem_wait = (w_active && mem_req && !mem_ack) || (r_state == MEM_WAIT && !mem_ack);
        w_flush    = w_active && !w_mem_wait && exmem_branch_taken;
        w_lu       = r_state == RUN && !w_mem_wait && !exmem_branch_taken && idex_memread &&
                     idex_rt != REG_ZERO && (idex_rt == ifid_rs || idex_rt == ifid_rt);
        w_tmo_nx   = r_state == MEM_WAIT ? r_tmo + 8'd1 : 8'd0;
        w_state_nx = r_state == ERR ? ERR :
                     r_state == MEM_WAIT ? (mem_ack ? RUN : w_tmo_nx >= 8'(MEM_TIMEOUT) ? ERR : MEM_WAIT) :
                     w_mem_wait ? MEM_WAIT : w_lu ? LU_STALL : RUN;
        pc_write     = !rst && r_state != ERR && !w_mem_wait && !w_lu;
        ifid_write   = pc_write;
        ifid_flush   = !rst && w_flush;
        idex_bubble  = !rst && (w_flush || w_lu);
        exmem_bubble = !rst && w_flush;
        pipe_hold    = rst || r_state == ERR || w_mem_wait;
        mem_err      = !rst && r_state == ERR;
    end

`ifdef HAZARD_PERF_CNT_EN
    pipe_sat_counter #(.WIDTH(CNT_W)) u_lu_cnt (
        .clk(clk), .rst(rst), .inc(w_lu), .cnt(lu_stall_cnt));
    pipe_sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
        .clk(clk), .rst(rst), .inc(w_flush), .cnt(flush_cnt));
    pipe_sat_counter #(.WIDTH(CNT_W)) u_mw_cnt (
        .clk(clk), .rst(rst), .inc(r_state == MEM_WAIT), .cnt(mem_wait_cnt));
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed vectors with hand-computed outputs for pipe_hazard_ctrl.
// Output vector order: pc_write, ifid_write, ifid_flush, idex_bubble, exmem_bubble, pipe_hold, mem_err.
module tb_pipe_hazard_ctrl;
    localparam logic [6:0] RUNO = 7'b1100000;
    localparam logic [6:0] RSTO = 7'b0000010;
    localparam logic [6:0] MEMO = 7'b0000010;
    localparam logic [6:0] LUO  = 7'b0001000;
    localparam logic [6:0] FLO  = 7'b1111100;
    localparam logic [6:0] ERRO = 7'b0000011;

    logic       clk = 0, rst = 1;
    logic       idex_memread = 0, exmem_branch_taken = 0, mem_req = 0, mem_ack = 0;
    logic [4:0] idex_rt = 0, ifid_rs = 0, ifid_rt = 0;
    logic       pc_write, ifid_write, ifid_flush, idex_bubble, exmem_bubble, pipe_hold, mem_err;
    int         checks = 0, errors = 0;
`ifdef HAZARD_PERF_CNT_EN
    logic [15:0] lu_stall_cnt, flush_cnt, mem_wait_cnt;
`endif

    pipe_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .idex_memread(idex_memread), .idex_rt(idex_rt),
        .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .exmem_branch_taken(exmem_branch_taken),
        .mem_req(mem_req), .mem_ack(mem_ack), .pc_write(pc_write), .ifid_write(ifid_write),
        .ifid_flush(ifid_flush), .idex_bubble(idex_bubble), .exmem_bubble(exmem_bubble),
        .pipe_hold(pipe_hold), .mem_err(mem_err)
`ifdef HAZARD_PERF_CNT_EN
        , .lu_stall_cnt(lu_stall_cnt), .flush_cnt(flush_cnt), .mem_wait_cnt(mem_wait_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%b exp=%b", tag, got, exp);
        end
    endtask

    task automatic step(input logic r, input logic mr, input logic [4:0] rt, input logic [4:0] rs,
                        input logic [4:0] frt, input logic br, input logic rq, input logic ak);
        @(posedge clk);
        #1;
        rst = r; idex_memread = mr; idex_rt = rt; ifid_rs = rs; ifid_rt = frt;
        exmem_branch_taken = br; mem_req = rq; mem_ack = ak;
        #1;
    endtask

    function automatic logic [15:0] outs();
        return {9'd0, pc_write, ifid_write, ifid_flush, idex_bubble, exmem_bubble, pipe_hold, mem_err};
    endfunction

    initial begin
        step(1, 0, 0, 0, 0, 0, 0, 0);  chk("rst_out", outs(), {9'd0, RSTO});
        step(0, 0, 0, 0, 0, 0, 0, 0);  chk("run_idle", outs(), {9'd0, RUNO});
        step(0, 1, 3, 3, 0, 0, 0, 0);  chk("lu_stall", outs(), {9'd0, LUO});
        step(0, 1, 3, 3, 0, 0, 0, 0);  chk("lu_mask", outs(), {9'd0, RUNO});
        step(0, 0, 0, 0, 0, 0, 0, 0);  chk("lu_done", outs(), {9'd0, RUNO});
`ifdef HAZARD_PERF_CNT_EN
        chk("lu_cnt1", lu_stall_cnt, 16'd1);
`endif
        step(0, 1, 0, 0, 0, 0, 0, 0);  chk("reg0", outs(), {9'd0, RUNO});
        step(0, 1, 7, 3, 4, 0, 0, 0);  chk("no_match", outs(), {9'd0, RUNO});
        step(0, 0, 3, 3, 3, 0, 0, 0);  chk("no_load", outs(), {9'd0, RUNO});
        step(0, 1, 9, 1, 9, 0, 0, 0);  chk("lu_rt", outs(), {9'd0, LUO});
        step(0, 0, 0, 0, 0, 0, 0, 0);  chk("lu_rt_done", outs(), {9'd0, RUNO});
        step(0, 1, 3, 3, 0, 1, 0, 0);  chk("flush", outs(), {9'd0, FLO});
        step(0, 0, 0, 0, 0, 0, 0, 0);  chk("post_flush", outs(), {9'd0, RUNO});
`ifdef HAZARD_PERF_CNT_EN
        chk("lu_cnt2", lu_stall_cnt, 16'd2);
        chk("flush_cnt1", flush_cnt, 16'd1);
`endif
        step(0, 0, 0, 0, 0, 0, 1, 1);  chk("req_ack", outs(), {9'd0, RUNO});
        step(0, 0, 0, 0, 0, 0, 1, 0);  chk("mw1", outs(), {9'd0, MEMO});
        step(0, 1, 5, 5, 0, 1, 1, 0);  chk("mw2", outs(), {9'd0, MEMO});
        step(0, 1, 5, 5, 0, 1, 1, 0);  chk("mw3", outs(), {9'd0, MEMO});
        step(0, 0, 0, 0, 0, 1, 1, 1);  chk("mw_ack", outs(), {9'd0, RUNO});
        step(0, 0, 0, 0, 0, 1, 0, 0);  chk("br_after_mw", outs(), {9'd0, FLO});
        step(0, 0, 0, 0, 0, 0, 0, 0);  chk("idle2", outs(), {9'd0, RUNO});
`ifdef HAZARD_PERF_CNT_EN
        chk("mw_cnt3", mem_wait_cnt, 16'd3);
        chk("flush_cnt2", flush_cnt, 16'd2);
`endif
        step(0, 0, 0, 0, 0, 0, 1, 0);  chk("to0", outs(), {9'd0, MEMO});
        for (int i = 1; i <= 4; i++) begin
            step(0, 0, 0, 0, 0, 0, 1, 0);
            chk($sformatf("to%0d", i), outs(), {9'd0, MEMO});
        end
        step(0, 0, 0, 0, 0, 0, 1, 0);  chk("err", outs(), {9'd0, ERRO});
        step(0, 1, 3, 3, 3, 1, 1, 1);  chk("err_sticky", outs(), {9'd0, ERRO});
        step(0, 0, 0, 0, 0, 0, 0, 1);  chk("err_sticky2", outs(), {9'd0, ERRO});
`ifdef HAZARD_PERF_CNT_EN
        chk("mw_cnt7", mem_wait_cnt, 16'd7);
`endif
        step(1, 0, 0, 0, 0, 0, 0, 0);  chk("err_rst", outs(), {9'd0, RSTO});
        step(0, 0, 0, 0, 0, 0, 0, 0);  chk("after_rst", outs(), {9'd0, RUNO});
`ifdef HAZARD_PERF_CNT_EN
        chk("cnt_clr", {lu_stall_cnt[4:0], flush_cnt[4:0], mem_wait_cnt[5:0]}, 16'd0);
`endif
        step(0, 0, 0, 0, 0, 0, 1, 0);  chk("mw_again", outs(), {9'd0, MEMO});
        step(0, 0, 0, 0, 0, 0, 1, 0);  chk("mw_again2", outs(), {9'd0, MEMO});
        step(1, 0, 0, 0, 0, 0, 1, 0);  chk("mw_rst", outs(), {9'd0, RSTO});
        step(0, 0, 0, 0, 0, 0, 0, 0);  chk("mw_rst_run", outs(), {9'd0, RUNO});
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
